riscv_rf_ctx_sequencer: RTL and testbench
=========================================

Name: riscv_rf_ctx_sequencer

Overview:
- Context save/restore engine for the RI5CY flip-flop register file. It acts as the initiator that drives one register-file read port and one write port.
- On a save request it reads x1..x(NUM_WORDS-1) in order and streams the values out over a valid/ready interface.
- On a restore request it accepts the same number of words over a valid/ready interface and writes them back in order.
- Used by the debug unit and by context-switch hardware. x0 is never read or written.

Parameters:
- ADDR_WIDTH, 5, register address width. NUM_WORDS = 2**ADDR_WIDTH (local).
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- save_req_i  in  1  start save; sampled only in IDLE
- restore_req_i  in  1  start restore; sampled only in IDLE
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle completion pulse
- rf_raddr_o  out  ADDR_WIDTH  register-file read address (combinational read port, zero latency)
- rf_rdata_i  in  DATA_WIDTH  register-file read data
- rf_waddr_o  out  ADDR_WIDTH  register-file write address, registered
- rf_wdata_o  out  DATA_WIDTH  register-file write data, registered
- rf_we_o  out  1  register-file write enable, registered
- sd_valid_o  out  1  save stream valid
- sd_data_o  out  DATA_WIDTH  save stream data
- sd_ready_i  in  1  save stream ready
- rs_valid_i  in  1  restore stream valid
- rs_data_i  in  DATA_WIDTH  restore stream data
- rs_ready_o  out  1  restore stream ready

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state = IDLE, idx = 1. busy_o, done_o, rf_raddr_o, rf_waddr_o, rf_wdata_o, rf_we_o, sd_valid_o and sd_data_o are all 0. rs_ready_o is 0 because it is decoded from state.
- Reset mid-operation: abort the operation, drop any buffered word and issue no further writes from the first clock edge with rst high. No done_o pulse.
- States: IDLE, SAVE, SAVE_DRAIN, RESTORE, RESTORE_FLUSH, DONE.
- IDLE:
  - save_req_i -> SAVE, idx = 1.
  - Otherwise restore_req_i -> RESTORE, idx = 1.
  - If both requests are high, save wins.
  - Requests are ignored in every other state and are not queued.
- SAVE:
  - rf_raddr_o = idx.
  - Load condition: !sd_valid_o || sd_ready_i.
  - On load: sd_data_o <= rf_rdata_i, sd_valid_o <= 1, idx <= idx+1.
  - The load with idx = NUM_WORDS-1 moves to SAVE_DRAIN.
  - Throughput is one word per cycle when sd_ready_i is held high.
  - sd_data_o and sd_valid_o stay stable while sd_valid_o && !sd_ready_i.
- SAVE_DRAIN:
  - rf_raddr_o = 0.
  - On sd_ready_i: sd_valid_o <= 0, go to DONE.
- RESTORE:
  - rs_ready_o = 1.
  - On rs_valid_i: rf_we_o <= 1, rf_waddr_o <= idx, rf_wdata_o <= rs_data_i, idx <= idx+1.
  - With no handshake: rf_we_o <= 0.
  - The handshake with idx = NUM_WORDS-1 moves to RESTORE_FLUSH.
- RESTORE_FLUSH:
  - rs_ready_o = 0.
  - The final write is visible on rf_we_o this cycle.
  - Next edge: rf_we_o <= 0, go to DONE.
- DONE: done_o = 1 for exactly one cycle, busy_o = 1, then IDLE. A new request is accepted the cycle after DONE.
- Write timing: every accepted restore word reaches the register file exactly one cycle after its handshake. Writes are in strictly ascending address order, 1..NUM_WORDS-1. rf_waddr_o is never 0 while rf_we_o = 1.
- idx arithmetic: ADDR_WIDTH bits wide. It never wraps because the terminal index is detected before the increment.
- Word count: every save emits exactly NUM_WORDS-1 words (31 at the default). Every restore consumes exactly NUM_WORDS-1 words. Extra rs_valid_i outside RESTORE is not acknowledged.

Test Plan:
1. Reg file preloaded with x_n = 0x1000_0000+n; pulse save_req_i with sd_ready_i = 1 -> 31 consecutive words 0x1000_0001..0x1000_001F on consecutive cycles, done_o one cycle after the last handshake, busy_o low the following cycle.
2. Save with sd_ready_i toggling 1,0,0,1,... (random 50%) -> same 31 words in order, no drop or duplicate, sd_data_o stable while stalled.
3. Restore of 31 words 0xA5A5_0001..0xA5A5_001F with rs_valid_i gapped every third cycle -> rf_we_o pulses with waddr 1..31 and matching data, each one cycle after its handshake, never waddr 0. Register file read back via a subsequent save matches.
4. save_req_i and restore_req_i high together in IDLE -> save runs and rs_ready_o stays 0. A restore_req_i pulsed mid-save is ignored, with exactly one done_o.
5. Assert rst for one cycle after the 10th restore handshake -> rf_we_o = 0 from that edge, state IDLE, no done_o. A fresh restore then writes from x1.
6. Back-to-back: a save_req_i held high continuously -> a second save starts the cycle after DONE. Each save produces 31 words and one done_o.

Source files
------------

// File: rtl/riscv_rf_ctx_sequencer.sv
// riscv_rf_ctx_sequencer: streams x1..x(N-1) out of the register file on save and writes them back on restore
module riscv_rf_ctx_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  save_req_i,
  input  logic                  restore_req_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  rf_we_o,
  output logic                  sd_valid_o,
  output logic [DATA_WIDTH-1:0] sd_data_o,
  input  logic                  sd_ready_i,
  input  logic                  rs_valid_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  output logic                  rs_ready_o
);
  localparam int NUM_WORDS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS-1);
  typedef enum logic [2:0] {IDLE, SAVE, SAVE_DRAIN, RESTORE, RESTORE_FLUSH, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] idx, idx_nxt;
  logic load, last;
  always_comb begin
    load = state == SAVE && (!sd_valid_o || sd_ready_i);
    last = idx == LAST;
    idx_nxt = last ? idx : idx + 1'b1;
    busy_o = state != IDLE;
    done_o = state == DONE;
    rs_ready_o = state == RESTORE;
    rf_raddr_o = state == SAVE ? idx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= FIRST;
      sd_valid_o <= 1'b0;
      sd_data_o <= '0;
      rf_we_o <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= 1'b0;
      case (state)
        IDLE: begin
          idx <= FIRST;
          if (save_req_i) state <= SAVE;
          else if (restore_req_i) state <= RESTORE;
        end
        SAVE: if (load) begin
          sd_data_o <= rf_rdata_i;
          sd_valid_o <= 1'b1;
          idx <= idx_nxt;
          if (last) state <= SAVE_DRAIN;
        end
        SAVE_DRAIN: if (sd_ready_i) begin
          sd_valid_o <= 1'b0;
          state <= DONE;
        end
        RESTORE: if (rs_valid_i) begin
          rf_we_o <= 1'b1;
          rf_waddr_o <= idx;
          rf_wdata_o <= rs_data_i;
          idx <= idx_nxt;
          if (last) state <= RESTORE_FLUSH;
        end
        RESTORE_FLUSH: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_rf_ctx_sequencer.sv
// tb_riscv_rf_ctx_sequencer: scoreboard bench with a register-file model for save/restore streams
module tb_riscv_rf_ctx_sequencer;
  logic clk = 0, rst = 1;
  logic save_req_i = 0, restore_req_i = 0;
  logic busy_o, done_o, rf_we_o, sd_valid_o, rs_ready_o;
  logic sd_ready_i = 0, rs_valid_i = 0;
  logic [4:0] rf_raddr_o, rf_waddr_o;
  logic [31:0] rf_rdata_i, rf_wdata_o, sd_data_o, rs_data_i = 0;
  logic pre = 1;
  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];
  logic [31:0] sq [$];
  logic [36:0] wq [$];
  int checks = 0, failures = 0, done_cnt = 0;
  logic hs_prev = 0, stall_prev = 0;
  logic [31:0] stall_data = 0;

  riscv_rf_ctx_sequencer dut (
    .clk(clk), .rst(rst), .save_req_i(save_req_i), .restore_req_i(restore_req_i),
    .busy_o(busy_o), .done_o(done_o), .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
    .sd_valid_o(sd_valid_o), .sd_data_o(sd_data_o), .sd_ready_i(sd_ready_i),
    .rs_valid_i(rs_valid_i), .rs_data_i(rs_data_i), .rs_ready_o(rs_ready_o)
  );

  always #5 clk = ~clk;
  assign rf_rdata_i = rf[rf_raddr_o];
  always @(posedge clk) begin
    if (pre) for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 + i;
    else if (rf_we_o) rf[rf_waddr_o] <= rf_wdata_o;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: save stream, stall stability, write timing and done pulses
  always @(negedge clk) begin
    if (stall_prev) chk("stall_hold", {31'b0, sd_valid_o, sd_data_o}, {32'h1, stall_data});
    if (sd_valid_o && sd_ready_i && !rst) begin
      if (sq.size() == 0) chk("extra_save_word", {32'b0, sd_data_o}, 64'hDEAD);
      else chk("save_word", {32'b0, sd_data_o}, {32'b0, sq.pop_front()});
    end
    stall_prev = sd_valid_o && !sd_ready_i && !rst;
    stall_data = sd_data_o;
    if (hs_prev) begin
      if (wq.size() == 0) chk("extra_write", 64'h1, 64'h0);
      else chk("write", {26'b0, rf_we_o, rf_waddr_o, rf_wdata_o}, {26'b0, 1'b1, wq.pop_front()});
    end else if (rf_we_o) chk("spurious_write", {32'b0, 27'b0, rf_waddr_o}, 64'hFFFF);
    if (rf_we_o && rf_waddr_o == 0) chk("waddr_zero", 64'h0, 64'h1);
    hs_prev = rs_valid_i && rs_ready_o && !rst;
    if (done_o) done_cnt++;
  end

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy_o && g < 2000) begin @(posedge clk); #1; g++; end
    if (busy_o) chk({name, "_timeout"}, 64'h1, 64'h0);
  endtask

  task automatic pulse(input logic save, input logic restore);
    save_req_i = save; restore_req_i = restore;
    @(posedge clk); #1;
    save_req_i = 0; restore_req_i = 0;
  endtask

  task automatic push_save();
    for (int i = 1; i < 32; i++) sq.push_back(exp_rf[i]);
  endtask

  task automatic do_save(input string name, input bit rnd);
    int d0 = done_cnt, g = 0;
    push_save();
    pulse(1, 0);
    while (busy_o && g < 2000) begin
      sd_ready_i = rnd ? 1'($urandom_range(1)) : 1'b1;
      @(posedge clk); #1; g++;
    end
    if (busy_o) chk({name, "_timeout"}, 64'h1, 64'h0);
    sd_ready_i = 0;
    chk({name, "_left"}, 64'(sq.size()), 64'h0);
    chk({name, "_done"}, 64'(done_cnt - d0), 64'h1);
  endtask

  task automatic do_restore(input logic [31:0] base, input int n, input bit gap);
    int sent = 0, cyc = 0;
    bit hs;
    while (sent < n && cyc < 500) begin
      rs_valid_i = !(gap && cyc % 3 == 2);
      rs_data_i = base + sent + 1;
      @(negedge clk);
      hs = rs_valid_i && rs_ready_o;
      if (hs) begin
        wq.push_back({5'(sent + 1), base + sent + 1});
        exp_rf[sent + 1] = base + sent + 1;
      end
      @(posedge clk); #1;
      if (hs) sent++;
      cyc++;
    end
    rs_valid_i = 0;
    if (sent < n) chk("restore_timeout", 64'(sent), 64'(n));
  endtask

  initial begin
    int d0, g;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'h1000_0000 + i;
    repeat (3) @(posedge clk);
    #1 rst = 0; pre = 0;
    @(negedge clk);
    chk("reset_outs", {busy_o, done_o, rf_we_o, sd_valid_o, rs_ready_o, rf_raddr_o, rf_waddr_o, rf_wdata_o},
        64'h0);
    chk("reset_sd_data", {32'b0, sd_data_o}, 64'h0);
    @(posedge clk); #1;

    // 1: full-rate save with cycle-exact framing
    d0 = done_cnt;
    push_save();
    sd_ready_i = 1;
    pulse(1, 0);
    @(negedge clk);
    chk("t1_first_cycle", {62'b0, busy_o, sd_valid_o}, 64'h2);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      chk("t1_valid", {63'b0, sd_valid_o}, 64'h1);
    end
    @(negedge clk);
    chk("t1_done", {62'b0, done_o, sd_valid_o}, 64'h2);
    @(negedge clk);
    chk("t1_idle", {62'b0, busy_o, done_o}, 64'h0);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'h1);
    chk("t1_left", 64'(sq.size()), 64'h0);
    sd_ready_i = 0;
    @(posedge clk); #1;

    // 2: save under random backpressure
    do_save("t2", 1);

    // 3: gapped restore then readback
    d0 = done_cnt;
    pulse(0, 1);
    do_restore(32'hA5A5_0000, 31, 1);
    wait_idle("t3");
    chk("t3_writes_left", 64'(wq.size()), 64'h0);
    chk("t3_done", 64'(done_cnt - d0), 64'h1);
    do_save("t3_readback", 0);

    // 4: simultaneous requests, save wins; mid-save restore request ignored
    d0 = done_cnt;
    push_save();
    sd_ready_i = 1;
    pulse(1, 1);
    g = 0;
    while (busy_o && g < 200) begin
      if (g == 10) restore_req_i = 1;
      @(negedge clk);
      chk("t4_rs_ready", {63'b0, rs_ready_o}, 64'h0);
      @(posedge clk); #1;
      restore_req_i = 0;
      g++;
    end
    sd_ready_i = 0;
    repeat (3) @(posedge clk);
    #1 chk("t4_stays_idle", {63'b0, busy_o}, 64'h0);
    chk("t4_done", 64'(done_cnt - d0), 64'h1);
    chk("t4_left", 64'(sq.size()), 64'h0);

    // 5: reset after the 10th restore handshake
    d0 = done_cnt;
    pulse(0, 1);
    do_restore(32'hC0DE_0000, 10, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t5_after_rst", {61'b0, busy_o, rf_we_o, rs_ready_o}, 64'h0);
    repeat (3) @(negedge clk);
    chk("t5_no_done", 64'(done_cnt - d0), 64'h0);
    chk("t5_writes_left", 64'(wq.size()), 64'h0);
    @(posedge clk); #1;
    pulse(0, 1);
    do_restore(32'h5A5A_0000, 31, 0);
    wait_idle("t5");
    chk("t5_done", 64'(done_cnt - d0), 64'h1);
    do_save("t5_readback", 0);

    // 6: back-to-back saves with the request held
    d0 = done_cnt;
    push_save();
    push_save();
    sd_ready_i = 1;
    save_req_i = 1;
    g = 0;
    while (done_cnt == d0 && g < 200) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    save_req_i = 0;
    chk("t6_restart", {63'b0, busy_o}, 64'h1);
    wait_idle("t6");
    sd_ready_i = 0;
    chk("t6_done", 64'(done_cnt - d0), 64'h2);
    chk("t6_left", 64'(sq.size()), 64'h0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
